// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants and types for the pipeline-boundary register.
// Occupancy encoding doubles as the value driven on occ_o.
package pipe_stage_skid_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned OCC_W      = 2;

   // RV32 canonical NOP (addi x0,x0,0); the natural bubble for instruction fields.
   localparam logic [31:0] BUBBLE_NOP = 32'h0000_0013;

   typedef enum logic [OCC_W-1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   typedef enum logic [1:0] {
      SLOT_HOLD,
      SLOT_LOAD,
      SLOT_DROP,
      SLOT_FLUSH
   } slot_cmd_e;

   function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
      return OCC_W'(main_v) + OCC_W'(skid_v);
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/payload channel between two pipeline stages.
// The producer side takes the master modport, the consumer side the slave modport.
interface pipe_stage_skid_if #(
   parameter int unsigned DATA_W = pipe_stage_skid_pkg::DATA_W_DEF
);

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One payload register plus its valid bit, driven by a single command per cycle.
// A flush parks the payload at BUBBLE so downstream never sees stale data.
module pipe_stage_skid_slot
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned       DATA_W = DATA_W_DEF,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  slot_cmd_e         cmd_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   // NOTE: the payload is a plain register, not a memory, so resetting it to
   // BUBBLE is cheap and keeps dn_data_o defined straight out of reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its inputs from before the edge.
         valid_q <= 1'b0;
         data_q  <= BUBBLE;
      end else begin
         case (cmd_i)
            SLOT_LOAD: begin
               valid_q <= 1'b1;
               data_q  <= data_i;
            end
            SLOT_DROP: begin
               valid_q <= 1'b0;
            end
            SLOT_FLUSH: begin
               valid_q <= 1'b0;
               data_q  <= BUBBLE;
            end
            default: begin
            end
         endcase
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-boundary register with stall, flush-to-bubble and an
// optional 2-entry skid buffer that makes up.ready a function of registered state.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned       DATA_W = DATA_W_DEF,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter bit                SKID   = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     flush_i,
   input  logic                     stall_i,
   pipe_stage_skid_if.slave         up,
   pipe_stage_skid_if.master        dn,
   output logic [OCC_W-1:0]         occ_o
);

   occ_e              state_q, state_d;
   slot_cmd_e         main_cmd, skid_cmd;
   logic              main_sel_skid;
   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_data, skid_data, main_din;
   logic              up_ready, up_fire, dn_fire;

   assign dn_fire = main_valid & dn.ready & ~stall_i & start_i;

   // With the skid slot the ready path sees only registered state; without it
   // the stage can accept in the same cycle its current entry leaves.
   assign up_ready = SKID ? (start_i & (state_q != OCC_TWO))
                          : (start_i & (~main_valid | dn_fire));
   assign up_fire  = up.valid & up_ready;
   assign up.ready = up_ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= OCC_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted before any branch;
      // a path that skipped one would otherwise infer a latch.
      state_d       = state_q;
      main_cmd      = SLOT_HOLD;
      skid_cmd      = SLOT_HOLD;
      main_sel_skid = 1'b0;

      if (flush_i) begin
         state_d  = OCC_EMPTY;
         main_cmd = SLOT_FLUSH;
         skid_cmd = SLOT_FLUSH;
      end else if (start_i) begin
         case (state_q)
            OCC_EMPTY: begin
               if (up_fire) begin
                  state_d  = OCC_ONE;
                  main_cmd = SLOT_LOAD;
               end
            end
            OCC_ONE: begin
               if (up_fire && dn_fire) begin
                  main_cmd = SLOT_LOAD;
               end else if (up_fire) begin
                  // Only reachable with the skid slot: the newcomer is younger.
                  state_d  = OCC_TWO;
                  skid_cmd = SLOT_LOAD;
               end else if (dn_fire) begin
                  state_d  = OCC_EMPTY;
                  main_cmd = SLOT_DROP;
               end
            end
            OCC_TWO: begin
               if (dn_fire) begin
                  state_d       = OCC_ONE;
                  main_cmd      = SLOT_LOAD;
                  main_sel_skid = 1'b1;
                  skid_cmd      = SLOT_DROP;
               end
            end
            default: begin
               state_d = OCC_EMPTY;
            end
         endcase
      end
   end

   assign main_din = main_sel_skid ? skid_data : up.data;

   pipe_stage_skid_slot #(
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
   ) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cmd_i   (main_cmd),
      .data_i  (main_din),
      .valid_o (main_valid),
      .data_o  (main_data)
   );

   generate
      if (SKID) begin : g_skid
         pipe_stage_skid_slot #(
            .DATA_W (DATA_W),
            .BUBBLE (BUBBLE)
         ) u_skid (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .cmd_i   (skid_cmd),
            .data_i  (up.data),
            .valid_o (skid_valid),
            .data_o  (skid_data)
         );
      end else begin : g_no_skid
         assign skid_valid = 1'b0;
         assign skid_data  = BUBBLE;
      end
   endgenerate

   assign dn.valid = main_valid;
   assign dn.data  = main_data;
   assign occ_o    = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance, each
// exercised in turn while the other is held in reset.
module tb_pipe_stage_skid;
   import pipe_stage_skid_pkg::*;

   localparam int unsigned DW  = 64;
   localparam logic [63:0] BUB = {32'h0, BUBBLE_NOP};

   logic          clk = 1'b0;
   logic          rst1, rst0;
   logic          start, flush, stall;
   logic          up_valid, dn_ready;
   logic [DW-1:0] up_data;
   logic [1:0]    occ1, occ0;
   logic          sel0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_skid_if #(.DATA_W(DW)) up1 ();
   pipe_stage_skid_if #(.DATA_W(DW)) dn1 ();
   pipe_stage_skid_if #(.DATA_W(DW)) up0 ();
   pipe_stage_skid_if #(.DATA_W(DW)) dn0 ();

   assign up1.valid = up_valid;
   assign up1.data  = up_data;
   assign dn1.ready = dn_ready;
   assign up0.valid = up_valid;
   assign up0.data  = up_data;
   assign dn0.ready = dn_ready;

   pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .SKID(1'b1)) u_dut1 (
      .clk_i   (clk),
      .rst_i   (rst1),
      .start_i (start),
      .flush_i (flush),
      .stall_i (stall),
      .up      (up1),
      .dn      (dn1),
      .occ_o   (occ1)
   );

   pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .SKID(1'b0)) u_dut0 (
      .clk_i   (clk),
      .rst_i   (rst0),
      .start_i (start),
      .flush_i (flush),
      .stall_i (stall),
      .up      (up0),
      .dn      (dn0),
      .occ_o   (occ0)
   );

   logic          cur_valid, cur_ready;
   logic [DW-1:0] cur_data;
   logic [1:0]    cur_occ;
   assign cur_valid = sel0 ? dn0.valid : dn1.valid;
   assign cur_ready = sel0 ? up0.ready : up1.ready;
   assign cur_data  = sel0 ? dn0.data  : dn1.data;
   assign cur_occ   = sel0 ? occ0      : occ1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dn(input string tag, input logic v, input logic [63:0] d, input logic [1:0] o);
      check({tag, ".valid"}, 64'(cur_valid), 64'(v));
      check({tag, ".data"},  cur_data, d);
      check({tag, ".occ"},   64'(cur_occ), 64'(o));
   endtask

   task automatic chk_rdy(input string tag, input logic r);
      check({tag, ".ready"}, 64'(cur_ready), 64'(r));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst1 = 1'b1; rst0 = 1'b1; sel0 = 1'b0;
      start = 1'b0; flush = 1'b0; stall = 1'b0;
      up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
      repeat (3) cyc();

      // ---------------- SKID = 1 ----------------
      chk_dn("s1_reset", 1'b0, BUB, 2'd0);
      rst1 = 1'b0; start = 1'b1;
      #1 chk_rdy("s1_reset", 1'b1);

      // Streaming: each word appears one cycle after it is offered.
      dn_ready = 1'b1; up_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         up_data = 64'(i);
         #1 chk_rdy("s1_stream", 1'b1);
         cyc();
         chk_dn("s1_stream", 1'b1, 64'(i), 2'd1);
      end

      // Backpressure: A goes to the skid slot, B waits until space returns.
      dn_ready = 1'b0; up_data = 64'hA;
      cyc();
      chk_dn("s1_bp_two", 1'b1, 64'd4, 2'd2);
      up_data = 64'hB;
      #1 chk_rdy("s1_bp_two", 1'b0);
      cyc();
      chk_dn("s1_bp_hold", 1'b1, 64'd4, 2'd2);
      dn_ready = 1'b1;
      cyc();
      chk_dn("s1_bp_a", 1'b1, 64'hA, 2'd1);
      chk_rdy("s1_bp_a", 1'b1);
      cyc();
      chk_dn("s1_bp_b", 1'b1, 64'hB, 2'd1);
      up_valid = 1'b0;
      cyc();
      chk_dn("s1_bp_empty", 1'b0, 64'hB, 2'd0);

      // Stall: the held word stays put, then leaves exactly once.
      up_valid = 1'b1; up_data = 64'hC0FFEE; dn_ready = 1'b0;
      cyc();
      up_valid = 1'b0; stall = 1'b1; dn_ready = 1'b1;
      repeat (3) begin
         cyc();
         chk_dn("s1_stall", 1'b1, 64'hC0FFEE, 2'd1);
      end
      stall = 1'b0;
      cyc();
      chk_dn("s1_stall_rel", 1'b0, 64'hC0FFEE, 2'd0);

      // Stall still lets one extra word in, then flush in TWO with 0xDEAD offered.
      stall = 1'b1; up_valid = 1'b1; up_data = 64'hE;
      cyc();
      up_data = 64'hF;
      cyc();
      chk_dn("s1_stall_two", 1'b1, 64'hE, 2'd2);
      flush = 1'b1; stall = 1'b0; dn_ready = 1'b0; up_data = 64'hDEAD;
      cyc();
      chk_dn("s1_flush", 1'b0, BUB, 2'd0);
      flush = 1'b0; up_valid = 1'b0;
      cyc();
      chk_dn("s1_flush_after", 1'b0, BUB, 2'd0);

      // start_i low freezes the stage in ONE.
      up_valid = 1'b1; up_data = 64'h55; dn_ready = 1'b1;
      cyc();
      start = 1'b0; up_data = 64'h66;
      #1 chk_rdy("s1_frozen", 1'b0);
      repeat (4) begin
         cyc();
         chk_dn("s1_frozen", 1'b1, 64'h55, 2'd1);
      end
      start = 1'b1;
      #1 chk_rdy("s1_resume", 1'b1);
      cyc();
      chk_dn("s1_resume", 1'b1, 64'h66, 2'd1);
      up_valid = 1'b0;
      cyc();

      // Asynchronous reset in TWO takes effect before the next edge.
      stall = 1'b1; up_valid = 1'b1; up_data = 64'h77;
      cyc();
      up_data = 64'h88;
      cyc();
      chk_dn("s1_pre_rst", 1'b1, 64'h77, 2'd2);
      up_valid = 1'b0;
      #3 rst1 = 1'b1;
      #1 chk_dn("s1_async_rst", 1'b0, BUB, 2'd0);
      cyc();
      rst1 = 1'b0; stall = 1'b0;
      #1 chk_rdy("s1_post_rst", 1'b1);

      // ---------------- SKID = 0 ----------------
      rst1 = 1'b1; rst0 = 1'b0; sel0 = 1'b1;
      up_valid = 1'b0; dn_ready = 1'b0;
      #1 chk_dn("s0_reset", 1'b0, BUB, 2'd0);
      chk_rdy("s0_reset", 1'b1);

      dn_ready = 1'b1; up_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         up_data = 64'(i);
         #1 chk_rdy("s0_stream", 1'b1);
         cyc();
         chk_dn("s0_stream", 1'b1, 64'(i), 2'd1);
      end

      // Ready follows dn_ready in the same cycle.
      dn_ready = 1'b0; up_data = 64'hA;
      #1 chk_rdy("s0_bp_low", 1'b0);
      cyc();
      chk_dn("s0_bp_hold", 1'b1, 64'd3, 2'd1);
      dn_ready = 1'b1;
      #1 chk_rdy("s0_bp_high", 1'b1);
      cyc();
      chk_dn("s0_bp_a", 1'b1, 64'hA, 2'd1);
      up_valid = 1'b0;
      cyc();
      chk_dn("s0_bp_empty", 1'b0, 64'hA, 2'd0);

      up_valid = 1'b1; up_data = 64'hC0FFEE;
      cyc();
      up_valid = 1'b0; stall = 1'b1;
      #1 chk_rdy("s0_stall", 1'b0);
      repeat (2) begin
         cyc();
         chk_dn("s0_stall", 1'b1, 64'hC0FFEE, 2'd1);
      end
      stall = 1'b0;
      cyc();
      chk_dn("s0_stall_rel", 1'b0, 64'hC0FFEE, 2'd0);

      // Flush while ready is high: the accepted 0xDEAD is discarded.
      up_valid = 1'b1; up_data = 64'hE;
      cyc();
      up_data = 64'hDEAD; flush = 1'b1;
      #1 chk_rdy("s0_flush", 1'b1);
      cyc();
      chk_dn("s0_flush", 1'b0, BUB, 2'd0);
      flush = 1'b0; up_valid = 1'b0;
      cyc();
      chk_dn("s0_flush_after", 1'b0, BUB, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
